// File: rtl/grayblast_pkg.sv
// Shared opcode field positions, sequencer sub-op codes and FSM states
// for the program sequencer.
package grayblast_pkg;

    localparam int OP_CLASS_HI = 15;
    localparam int OP_CLASS_LO = 14;
    localparam int OP_SEQ_BIT  = 3;
    localparam int OP_SUB_HI   = 2;
    localparam int OP_SUB_LO   = 0;
    localparam int OP_CNT_HI   = 13;
    localparam int OP_CNT_LO   = 8;

    localparam logic [1:0] OP_CLASS_CTRL = 2'b11;

    localparam logic [2:0] SEQ_END     = 3'b000;
    localparam logic [2:0] SEQ_LOOP    = 3'b001;
    localparam logic [2:0] SEQ_ENDLOOP = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    function automatic logic is_seq_ctrl(input logic [15:0] w);
        return (w[OP_CLASS_HI:OP_CLASS_LO] == OP_CLASS_CTRL) && w[OP_SEQ_BIT];
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: register file with one synchronous write port and
// one asynchronous read port. Contents are not reset.
module seq_prog_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Instruction sequencer feeding the core array one opcode per clock.
// Optional single-step control is built when PROGRAM_SEQ_STEP_EN is defined.
module program_sequencer
    import grayblast_pkg::*;
#(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = $clog2(PROG_DEPTH),
    parameter int LOOP_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              start,
`ifdef PROGRAM_SEQ_STEP_EN
    input  logic              step,
    input  logic              step_mode,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       opcode,
    output logic              execute
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] lstart_q, lstart_d;
    logic [LOOP_W-1:0] cnt_q, cnt_d;
    logic [15:0]       op_q, op_d;
    logic              exe_q, exe_d;
    logic              wrap_q, wrap_d;

    logic [15:0]       word;
    logic              adv;
    logic              last;
    logic              ctrl;
    logic [2:0]        sub;
    logic [ADDR_W-1:0] pc_inc;

    seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (word)
    );

`ifdef PROGRAM_SEQ_STEP_EN
    assign adv = !step_mode || step;
`else
    assign adv = 1'b1;
`endif

    assign last   = (pc_q == ADDR_W'(PROG_DEPTH - 1));
    assign ctrl   = is_seq_ctrl(word);
    assign sub    = word[OP_SUB_HI:OP_SUB_LO];
    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lstart_d = lstart_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        exe_d    = 1'b0;
        wrap_d   = wrap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    wrap_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (adv) begin
                    // last word was issued; let it show before done
                    if (wrap_q) begin
                        state_d = ST_DONE;
                        wrap_d  = 1'b0;
                    end else if (ctrl) begin
                        unique case (1'b1)
                            (sub == SEQ_END): begin
                                state_d = ST_DONE;
                            end
                            (sub == SEQ_ENDLOOP) && (cnt_q != '0): begin
                                cnt_d = cnt_q - LOOP_W'(1);
                                pc_d  = lstart_q;
                            end
                            default: begin
                                if (sub == SEQ_LOOP) begin
                                    cnt_d    = LOOP_W'(word[OP_CNT_HI:OP_CNT_LO]);
                                    lstart_d = pc_inc;
                                end
                                if (last) begin
                                    state_d = ST_DONE;
                                end else begin
                                    pc_d = pc_inc;
                                end
                            end
                        endcase
                    end else begin
                        op_d  = word;
                        exe_d = 1'b1;
                        if (last) begin
                            wrap_d = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            lstart_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            exe_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            lstart_q <= lstart_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            exe_q    <= exe_d;
            wrap_q   <= wrap_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign pc      = pc_q;
    assign opcode  = op_q;
    assign execute = exe_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: directed programs, expected
// opcodes queued at issue and compared by a negedge monitor.
module tb_program_sequencer;

    localparam logic [15:0] W_END     = 16'hC008;
    localparam logic [15:0] W_ENDLOOP = 16'hC00A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        start = 1'b0;
    logic        busy, done, execute;
    logic [4:0]  pc;
    logic [15:0] opcode;
`ifdef PROGRAM_SEQ_STEP_EN
    logic        step = 1'b0;
    logic        step_mode = 1'b0;
    logic        prev_step = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [4:0]  end_pc;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
`ifdef PROGRAM_SEQ_STEP_EN
        .step      (step),
        .step_mode (step_mode),
`endif
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .opcode    (opcode),
        .execute   (execute)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: every execute pops one expected opcode
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                chk("exec_in_done", 32'(execute), 32'd0);
            end
            if (execute) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_exec: got %0h want none", opcode);
                end else begin
                    chk("opcode", 32'(opcode), 32'(exp_q.pop_front()));
                end
`ifdef PROGRAM_SEQ_STEP_EN
                if (step_mode) chk("step_lat", 32'(prev_step), 32'd1);
`endif
            end
        end
`ifdef PROGRAM_SEQ_STEP_EN
        prev_step = step;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic load_prog1();
        load(5'd0, 16'h0001);
        load(5'd1, 16'h0002);
        load(5'd2, W_END);
    endtask

    task automatic run(input bit lat, input bit poke, output logic [4:0] epc);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        epc = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (lat) begin
            chk("busy_after_start", 32'(busy), 32'd1);
            chk("exec_t1", 32'(execute), 32'd0);
            tick();
            chk("exec_t2", 32'(execute), 32'd1);
        end
        if (poke) begin
            start = 1'b1;
            prog_we = 1'b1;
            prog_addr = 5'd0;
            prog_data = 16'h00AA;
            tick();
            start = 1'b0;
            prog_we = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
`ifdef PROGRAM_SEQ_STEP_EN
            if (step_mode) step = (i % 3 == 2);
`endif
            tick();
        end
`ifdef PROGRAM_SEQ_STEP_EN
        step = 1'b0;
`endif
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got none want done");
        end
        epc = pc;
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_low", 32'(done), 32'd0);
        chk("done_once", 32'(done_cnt), 32'(d0 + 1));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_exec", 32'(execute), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic program with start-latency check
        load_prog1();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        run(1, 0, end_pc);
        chk("t1_end_pc", 32'(end_pc), 32'd2);

        // loop N=3: body issued four times
        load(5'd0, 16'hC309);
        load(5'd1, 16'h0010);
        load(5'd2, W_ENDLOOP);
        load(5'd3, W_END);
        repeat (4) exp_q.push_back(16'h0010);
        run(0, 0, end_pc);
        chk("t2_end_pc", 32'(end_pc), 32'd3);

        // full store without END: implicit stop at last word
        for (int i = 0; i < 32; i++) begin
            load(5'(i), 16'h0100 + 16'(i));
            exp_q.push_back(16'h0100 + 16'(i));
        end
        run(0, 0, end_pc);
        chk("t3_end_pc", 32'(end_pc), 32'd31);
        chk("t3_pc_hold", 32'(pc), 32'd31);

        // start and write while busy are dropped
        load_prog1();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        run(0, 1, end_pc);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        run(0, 0, end_pc);

        // reset mid-loop
        load(5'd0, 16'hFF09);
        load(5'd1, 16'h0010);
        load(5'd2, W_ENDLOOP);
        load(5'd3, W_END);
        repeat (64) exp_q.push_back(16'h0010);
        begin
            int d0;
            d0 = done_cnt;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (10) tick();
            chk("busy_mid", 32'(busy), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_exec", 32'(execute), 32'd0);
            chk("arst_busy", 32'(busy), 32'd0);
            chk("arst_pc", 32'(pc), 32'd0);
            chk("arst_opcode", 32'(opcode), 32'd0);
            repeat (2) tick();
            exp_q.delete();
            rst_n = 1'b1;
            tick();
            chk("arst_no_done", 32'(done_cnt), 32'(d0));
        end
        load_prog1();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        run(1, 0, end_pc);

`ifdef PROGRAM_SEQ_STEP_EN
        step_mode = 1'b1;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        run(0, 0, end_pc);
        chk("t6_end_pc", 32'(end_pc), 32'd2);
        step_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
